// File: rtl/hazard_controller.sv
// Purpose: pipeline sequencing controller (load-use stall, redirect flush, memory wait freeze) with perf counters.
// Latency: control outputs are combinational from the inputs; counters and timeout flag update one cycle later.
// Backpressure: mem_ready low while an access is in EX_MEM freezes every stage except a bubble into WB.
module hazard_controller #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_dest,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic [1:0]       ex_mem_pcsrc,
    input  logic             ex_mem_memread,
    input  logic             ex_mem_memwrite,
    input  logic             mem_ready,
    input  logic             cnt_clear,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             mem_req,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam logic [7:0]       LP_MAX_WAIT = 8'(MAX_WAIT);
    localparam logic [7:0]       LP_WAIT_SAT = 8'hFF;
    localparam logic [CNT_W-1:0] LP_CNT_SAT  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_wait;
    logic [7:0]       w_wait_inc;
    logic             r_timeout;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_access;
    logic             w_mem_stall;
    logic             w_lu;
    logic             w_redir;
    logic             w_stall_inc;
    logic             w_wait_cycle;

    // Hazard terms. A redirect is held off while memory stalls so the
    // branch in EX_MEM is not lost; it is taken in the mem_ready cycle.
    assign w_access     = ex_mem_memread | ex_mem_memwrite;
    assign w_mem_stall  = w_access & ~mem_ready;
    assign w_lu         = id_ex_memread & (id_ex_dest != 5'd0) &
                          ((id_ex_dest == if_id_rs) |
                           (if_id_uses_rt & (id_ex_dest == if_id_rt)));
    assign w_redir      = (ex_mem_pcsrc != 2'b00) & ~w_mem_stall;
    assign w_stall_inc  = w_mem_stall | (w_lu & ~w_redir);
    assign w_wait_cycle = (r_state == ST_MEM_WAIT) & ~mem_ready;
    assign w_wait_inc   = (r_wait == LP_WAIT_SAT) ? r_wait : (r_wait + 8'd1);

    assign mem_timeout  = r_timeout;
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;

    // State register; reset aborts any outstanding memory wait.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus Mealy pipeline controls, priority mem_stall > redir > lu.
    always_comb begin
        w_state_nxt  = r_state;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        mem_req      = w_access;

        case (r_state)
            ST_RUN:      if (w_mem_stall) w_state_nxt = ST_MEM_WAIT;
            ST_MEM_WAIT: if (mem_ready)   w_state_nxt = ST_RUN;
            default:     w_state_nxt = ST_RUN;
        endcase

        if (!reset) begin
            // Hold every stage cleared while reset is low, independent of clock.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
            mem_req      = 1'b0;
        end else if (w_mem_stall) begin
            // Freeze the pipe; WB still advances but receives a bubble.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (w_redir) begin
            // Squash wrong-path work; the branch itself moves on into WB.
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (w_lu) begin
            // Hold PC and IF_ID one cycle, insert a bubble into ID_EX.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
        end
    end

    // Memory wait counter: restarts on entering the wait, saturates at 255.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wait <= 8'd0;
        end else if ((r_state == ST_RUN) && w_mem_stall) begin
            r_wait <= 8'd0;
        end else if (w_wait_cycle) begin
            r_wait <= w_wait_inc;
        end
    end

    // Sticky timeout: set once a wait reaches MAX_WAIT, cleared only by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_timeout <= 1'b0;
        end else if (w_wait_cycle && (w_wait_inc >= LP_MAX_WAIT)) begin
            r_timeout <= 1'b1;
        end
    end

    // Saturating stall counter; clear wins over increment.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (cnt_clear) begin
            r_stall_cnt <= '0;
        end else if (w_stall_inc && (r_stall_cnt != LP_CNT_SAT)) begin
            r_stall_cnt <= r_stall_cnt + LP_CNT_ONE;
        end
    end

    // Saturating redirect counter; clear wins over increment.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_flush_cnt <= '0;
        end else if (cnt_clear) begin
            r_flush_cnt <= '0;
        end else if (w_redir && (r_flush_cnt != LP_CNT_SAT)) begin
            r_flush_cnt <= r_flush_cnt + LP_CNT_ONE;
        end
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the 5-stage core. It drives the `write` (advance) and `reset` (flush to bubble) controls of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers, plus the PC write enable. It resolves three conditions:
- load-use hazards, with a one-cycle stall;
- taken control transfers flagged by `PCsrc` in EX_MEM, by flushing the wrong-path stages;
- multi-cycle data-memory accesses, through a req/ready handshake that freezes the pipe.

It also keeps saturating stall/flush counters and a sticky memory-timeout flag.

## Interface
- `MAX_WAIT`, default 255: memory wait cycles before `mem_timeout` sets; range 1..255.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `id_ex_memread`  in  1  MemRead of the instruction in ID_EX.
- `id_ex_dest`  in  5  Dest_Reg_Addr of the instruction in ID_EX.
- `if_id_rs`  in  5  rs field of the instruction in IF_ID.
- `if_id_rt`  in  5  rt field of the instruction in IF_ID.
- `if_id_uses_rt`  in  1  the IF_ID instruction reads rt as a source.
- `ex_mem_pcsrc`  in  2  PCsrc of EX_MEM; nonzero = redirect.
- `ex_mem_memread`  in  1  MemRead of EX_MEM.
- `ex_mem_memwrite`  in  1  MemWrite of EX_MEM.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `cnt_clear`  in  1  synchronous clear of both counters.
- `pc_write`  out  1  PC update enable.
- `if_id_write`, `id_ex_write`, `ex_mem_write`, `mem_wb_write`  out  1 each  pipeline register write enables.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`, `mem_wb_flush`  out  1 each  pipeline register synchronous clears (active-high).
- `mem_req`  out  1  data memory access request.
- `mem_timeout`  out  1  sticky flag: a wait exceeded `MAX_WAIT`.
- `stall_cnt`  out  `CNT_W`  saturating count of stalled cycles.
- `flush_cnt`  out  `CNT_W`  saturating count of redirect events.

## Operation
FSM states:
- **RUN**: normal operation.
- **MEM_WAIT**: a memory access is outstanding.

Internal terms:
- `access = ex_mem_memread | ex_mem_memwrite`.
- `mem_req = access`, in either state.
- `mem_stall = access & ~mem_ready`.
- `lu = id_ex_memread & (id_ex_dest != 0) & ((id_ex_dest == if_id_rs) | (if_id_uses_rt & (id_ex_dest == if_id_rt)))`.
- `redir = (ex_mem_pcsrc != 0) & ~mem_stall`.

Outputs are combinational from the inputs (Mealy). Priority is `mem_stall` > `redir` > `lu` > none.
- **mem_stall**: all `*_write` = 0 except `mem_wb_write` = 1. `mem_wb_flush` = 1, so a bubble enters WB. Other flushes = 0. `pc_write` = 0.
- **redir**: all writes = 1, `pc_write` = 1. `if_id_flush` = `id_ex_flush` = `ex_mem_flush` = 1. `mem_wb_flush` = 0, so the branch itself retires.
- **lu**: `pc_write` = `if_id_write` = 0. `id_ex_write` = 1 with `id_ex_flush` = 1 (bubble). `ex_mem_write` = `mem_wb_write` = 1. Other flushes = 0.
- **none**: all writes = 1, all flushes = 0.

FSM transitions:
- RUN → MEM_WAIT when `mem_stall`.
- MEM_WAIT → RUN when `mem_ready`.

Wait counter (8-bit):
- Cleared on entry to MEM_WAIT; increments each MEM_WAIT cycle with `~mem_ready`; saturates at 255.
- When it reaches `MAX_WAIT`, `mem_timeout` sets. It stays set until reset. `mem_req` stays high.

Performance counters:
- `stall_cnt` increments each cycle with `mem_stall | (lu & ~redir)`.
- `flush_cnt` increments each cycle with `redir`.
- Both saturate at all-ones. `cnt_clear` has priority over increment (the result is 0).

## Timing
- While `reset` is low, independent of `clock`:
  - all `*_write` and `pc_write` = 0;
  - all `*_flush` = 1;
  - `mem_req` = 0.
- Reset values: state RUN, wait counter 0, `mem_timeout` 0, `stall_cnt` = `flush_cnt` = 0.
- First rising edge after `reset` goes high: normal operation.
- Control outputs respond in the same cycle as their inputs (zero latency). Counter and flag updates are visible one cycle later.
- Load-use costs exactly 1 stall cycle. On the next cycle the bubble is in ID_EX, so `lu` = 0.
- A memory access with `mem_ready` high in its first EX_MEM cycle costs 0 stall cycles.
- A redirect coincident with `mem_stall` is deferred until the memory completes. It is then taken in the `mem_ready` cycle.
- Reset asserted in MEM_WAIT aborts the wait immediately; `mem_req` drops to 0.

## Test plan
- **Load-use.** `id_ex_memread`=1, `id_ex_dest`=5, `if_id_rs`=5, no other condition. Required: `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1 for one cycle; `stall_cnt` = 1 afterwards. Repeat with `id_ex_dest`=0: no stall.
- **Redirect.** `ex_mem_pcsrc`=2'b01, with `lu` also true. Required: `if_id_flush`=`id_ex_flush`=`ex_mem_flush`=1, `pc_write`=1, `mem_wb_flush`=0. `flush_cnt`=1; `stall_cnt` unchanged.
- **Memory wait.** `ex_mem_memread`=1, `mem_ready` low for 3 cycles, then high. Required: `mem_req`=1 for 4 cycles; 3 cycles with all writes 0 except `mem_wb_write`, plus `mem_wb_flush`=1; `stall_cnt`=3; state back in RUN.
- **Timeout.** `MAX_WAIT`=4, `mem_ready` held low for 6 cycles. Required: `mem_timeout` rises after the 4th wait cycle; it stays 1 after `mem_ready` and until reset.
- **Async reset mid-wait.** Drop `reset` in MEM_WAIT, off a clock edge. Required: outputs go immediately to the reset values (`mem_req`=0, writes 0, flushes 1); counters read 0 after release.
- **Saturation and clear.** `CNT_W`=4, 20 load-use cycles. Required: `stall_cnt`=15. `cnt_clear` pulse together with a stall gives 0.
